// File: rtl/rle_compress.sv
// rle_compress: run-length encoder, byte stream in (MSB first) -> 3-bit run
// tokens {value, count[1:0]} out, framed by a work/done job handshake.
// Optional feature macro: RLE_COMPRESS_TOKCNT_EN adds a tok_count output that
// counts token transfers for the current job.
module rle_compress (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        work,
  input  logic [31:0] len,
  input  logic [7:0]  in_byte,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [2:0]  tok,
  output logic        tok_valid,
  input  logic        tok_ready,
  output logic [31:0] byteIndx,
  output logic [3:0]  bitIndx,
  output logic        done
`ifdef RLE_COMPRESS_TOKCNT_EN
  ,
  output logic [31:0] tok_count
`endif
);

  typedef enum logic [2:0] {IDLE, LOAD, SCAN, EMIT, FLUSH, DONE} state_t;

  state_t      state_q, state_d;
  logic [31:0] len_q, len_d;
  logic [31:0] bidx_q, bidx_d;
  logic [3:0]  bit_q, bit_d;
  logic [7:0]  byte_q, byte_d;
  logic        val_q, val_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [2:0]  tok_q, tok_d;
  logic        tokv_q, tokv_d;
  logic        inrdy_q, inrdy_d;
  logic        done_q, done_d;
  logic        scan_bit;
  logic        consume;
`ifdef RLE_COMPRESS_TOKCNT_EN
  logic [31:0] tcnt_q, tcnt_d;
`endif

  // Next-state and next-output computation; every output is registered, so
  // each transition also sets the value the outputs take in the new state.
  always_comb begin
    state_d  = state_q;
    len_d    = len_q;
    bidx_d   = bidx_q;
    bit_d    = bit_q;
    byte_d   = byte_q;
    val_d    = val_q;
    cnt_d    = cnt_q;
    tok_d    = tok_q;
    tokv_d   = tokv_q;
    inrdy_d  = inrdy_q;
    done_d   = done_q;
    consume  = 1'b0;
    scan_bit = byte_q[bit_q[2:0]];
`ifdef RLE_COMPRESS_TOKCNT_EN
    tcnt_d   = tcnt_q + {31'd0, tokv_q & tok_ready};
`endif
    case (state_q)
      IDLE: begin
        if (work) begin
`ifdef RLE_COMPRESS_TOKCNT_EN
          tcnt_d = 32'd0;
`endif
          if (len != 32'd0) begin
            len_d   = len;
            bidx_d  = 32'd0;
            cnt_d   = 2'd0;
            inrdy_d = 1'b1;
            state_d = LOAD;
          end else begin
            done_d  = 1'b1;
            state_d = DONE;
          end
        end
      end
      LOAD: begin
        if (in_valid) begin
          byte_d  = in_byte;
          bit_d   = 4'd7;
          inrdy_d = 1'b0;
          state_d = SCAN;
        end
      end
      SCAN: begin
        if (cnt_q == 2'd0) begin
          val_d   = scan_bit;
          cnt_d   = 2'd1;
          consume = 1'b1;
        end else if (scan_bit == val_q && cnt_q != 2'd3) begin
          cnt_d   = cnt_q + 2'd1;
          consume = 1'b1;
        end else begin
          // run broken or full: emit it, the current bit is re-examined later
          tok_d   = {val_q, cnt_q};
          tokv_d  = 1'b1;
          state_d = EMIT;
        end
        if (consume) begin
          if (bit_q == 4'd0) begin
            if (bidx_q == len_q - 32'd1) begin
              tok_d   = {val_d, cnt_d};
              tokv_d  = (cnt_d != 2'd0);
              state_d = FLUSH;
            end else begin
              bidx_d  = bidx_q + 32'd1;
              inrdy_d = 1'b1;
              state_d = LOAD;
            end
          end else begin
            bit_d = bit_q - 4'd1;
          end
        end
      end
      EMIT: begin
        if (tok_ready) begin
          tokv_d  = 1'b0;
          cnt_d   = 2'd0;
          state_d = SCAN;
        end
      end
      FLUSH: begin
        // an empty final run has nothing to present and finishes directly
        if (!tokv_q || tok_ready) begin
          tokv_d  = 1'b0;
          cnt_d   = 2'd0;
          done_d  = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        if (!work) begin
          done_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      len_q   <= 32'd0;
      bidx_q  <= 32'd0;
      bit_q   <= 4'd0;
      byte_q  <= 8'd0;
      val_q   <= 1'b0;
      cnt_q   <= 2'd0;
      tok_q   <= 3'd0;
      tokv_q  <= 1'b0;
      inrdy_q <= 1'b0;
      done_q  <= 1'b0;
`ifdef RLE_COMPRESS_TOKCNT_EN
      tcnt_q  <= 32'd0;
`endif
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      bidx_q  <= bidx_d;
      bit_q   <= bit_d;
      byte_q  <= byte_d;
      val_q   <= val_d;
      cnt_q   <= cnt_d;
      tok_q   <= tok_d;
      tokv_q  <= tokv_d;
      inrdy_q <= inrdy_d;
      done_q  <= done_d;
`ifdef RLE_COMPRESS_TOKCNT_EN
      tcnt_q  <= tcnt_d;
`endif
    end
  end

  assign in_ready  = inrdy_q;
  assign tok       = tok_q;
  assign tok_valid = tokv_q;
  assign byteIndx  = bidx_q;
  assign bitIndx   = bit_q;
  assign done      = done_q;
`ifdef RLE_COMPRESS_TOKCNT_EN
  assign tok_count = tcnt_q;
`endif

endmodule

// File: tb/tb_rle_compress.sv
// Bench for rle_compress: table of jobs with expected token streams pushed to
// a scoreboard queue, plus hand-written reset sequences.
module tb_rle_compress;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        work = 1'b0;
  logic [31:0] len = 32'd0;
  logic [7:0]  in_byte = 8'd0;
  logic        in_valid = 1'b0;
  logic        tok_ready = 1'b0;
  logic        in_ready;
  logic [2:0]  tok;
  logic        tok_valid;
  logic [31:0] byteIndx;
  logic [3:0]  bitIndx;
  logic        done;
`ifdef RLE_COMPRESS_TOKCNT_EN
  logic [31:0] tok_count;
`endif

  rle_compress dut (
    .clk(clk), .rst_n(rst_n), .work(work), .len(len),
    .in_byte(in_byte), .in_valid(in_valid), .in_ready(in_ready),
    .tok(tok), .tok_valid(tok_valid), .tok_ready(tok_ready),
    .byteIndx(byteIndx), .bitIndx(bitIndx), .done(done)
`ifdef RLE_COMPRESS_TOKCNT_EN
    , .tok_count(tok_count)
`endif
  );

  always #5 clk = ~clk;

  // bytes: byte k at [8k+7:8k]; toks: token k at [3k+2:3k]
  typedef struct {
    int          len;
    logic [31:0] bytes;
    int          nt;
    logic [47:0] toks;
    int          stall_at;
    bit          rnd;
  } vec_t;

  int         n_vec = 0;
  int         n_err = 0;
  logic [2:0] exp_q[$];
  vec_t       vecs[6];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_zero_outs(input string tag);
    chk({tag, "_in_ready"}, in_ready, 0);
    chk({tag, "_tok_valid"}, tok_valid, 0);
    chk({tag, "_tok"}, tok, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_byteIndx"}, byteIndx, 0);
    chk({tag, "_bitIndx"}, bitIndx, 0);
  endtask

  task automatic run_job(input vec_t v);
    int         byte_i = 0;
    int         idx = 0;
    int         stall_left = 5;
    int         cyc = 0;
    int         last_x = -10;
    bit         got_done = 0;
    bit         ir_bad = 0;
    bit         prev_v = 0;
    bit         prev_r = 0;
    bit         chk_scan = 0;
    logic [2:0] prev_t = 3'd0;
    for (int k = 0; k < v.nt; k++) exp_q.push_back(v.toks[3*k +: 3]);
    @(negedge clk);
    work = 1'b1;
    len = v.len;
    tok_ready = 1'b0;
    while (cyc < 3000 && !got_done) begin
      @(negedge clk);
      cyc++;
      if (prev_v && !prev_r) chk("tok_hold", {tok_valid, tok}, {1'b1, prev_t});
      if (chk_scan) begin
        chk("scan_byteIndx", byteIndx, byte_i - 1);
        chk("scan_bitIndx", bitIndx, 7);
        chk_scan = 0;
      end
      in_valid = 1'b0;
      if (in_ready) begin
        if (byte_i < v.len) begin
          in_valid = 1'b1;
          in_byte = v.bytes[8*byte_i +: 8];
          byte_i++;
          chk_scan = 1;
        end else ir_bad = 1;
      end
      if (tok_valid && idx == v.stall_at && stall_left > 0) begin
        tok_ready = 1'b0;
        stall_left--;
        chk("stall_tok", tok, v.toks[3*idx +: 3]);
      end else begin
        tok_ready = v.rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      end
      if (done) begin
        got_done = 1;
        if (v.nt > 0) chk("done_latency", cyc - last_x, 1);
        else chk("done_latency_len0", (cyc <= 2), 1);
      end
      if (tok_valid && tok_ready) begin
        if (exp_q.size() == 0) begin
          chk("extra_tok", tok, 3'd0);
          n_err += (tok == 3'd0) ? 1 : 0;
        end else chk("tok", tok, exp_q.pop_front());
        idx++;
        last_x = cyc;
      end
      prev_v = tok_valid;
      prev_r = tok_ready;
      prev_t = tok;
    end
    chk("done", got_done, 1);
    chk("tok_left", exp_q.size(), 0);
    chk("bytes_used", byte_i, v.len);
    chk("in_ready_extra", ir_bad, 0);
`ifdef RLE_COMPRESS_TOKCNT_EN
    chk("tok_count", tok_count, v.nt);
`endif
    work = 1'b0;
    tok_ready = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    chk("done_clear", done, 0);
    exp_q.delete();
  endtask

  initial begin
    vecs[0] = '{1, 32'h0F, 4, {3'd5, 3'd7, 3'd1, 3'd3}, -1, 1'b0};
    vecs[1] = '{1, 32'h00, 3, {3'd2, 3'd3, 3'd3}, -1, 1'b0};
    vecs[2] = '{2, 32'h80FF, 6, {3'd1, 3'd3, 3'd3, 3'd7, 3'd7, 3'd7}, -1, 1'b0};
    vecs[3] = '{1, 32'h55, 8, {3'd5, 3'd1, 3'd5, 3'd1, 3'd5, 3'd1, 3'd5, 3'd1}, 1, 1'b0};
    vecs[4] = '{0, 32'h0, 0, 48'd0, -1, 1'b0};
    vecs[5] = '{3, 32'h013CA5, 14,
                {3'd5, 3'd3, 3'd3, 3'd3, 3'd5, 3'd7, 3'd2, 3'd5,
                 3'd1, 3'd5, 3'd2, 3'd5, 3'd1, 3'd5}, -1, 1'b1};

    // power-on reset
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk_zero_outs("reset");
`ifdef RLE_COMPRESS_TOKCNT_EN
    chk("reset_tok_count", tok_count, 0);
`endif
    rst_n = 1'b1;

    for (int i = 0; i < 6; i++) run_job(vecs[i]);

    // reset during SCAN of byte 0 of a 4-byte job, with in_valid held high
    @(negedge clk);
    work = 1'b1;
    len = 32'd4;
    for (int c = 0; c < 20 && !in_ready; c++) @(negedge clk);
    chk("rst_job_in_ready", in_ready, 1);
    in_valid = 1'b1;
    in_byte = 8'hAA;
    @(negedge clk);
    in_valid = 1'b0;
    work = 1'b0;
    @(negedge clk);
    chk("rst_job_scanning", bitIndx < 4'd8 && !in_ready && !done, 1);
    rst_n = 1'b0;
    in_valid = 1'b1;
    @(negedge clk);
    chk_zero_outs("midjob_reset");
    rst_n = 1'b1;
    in_valid = 1'b0;
    @(negedge clk);
    chk_zero_outs("after_reset_idle");
    run_job(vecs[0]);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/rle_compress.md
# rle_compress

Run-length encoder for the DCNN IO path, the transmit-side counterpart of the `decompress` block. It consumes a packed bitstream one byte at a time, MSB first, and emits 3-bit run tokens: bit 2 is the run value and bits 1:0 are the run length (1..3). The tokens are the format `decompress` expands back into bytes. A single `work`/`done` job handshake frames each transfer of `len` bytes.

## Interface
Parameters:
- none

Ports:
- `clk`  input  1  single clock; all logic is rising-edge.
- `rst_n`  input  1  reset, synchronous and active-low.
- `work`  input  1  job request; sampled in IDLE.
- `len`  input  32  job length in bytes; sampled with `work`.
- `in_byte`  input  8  input data byte.
- `in_valid`  input  1  `in_byte` is valid.
- `in_ready`  output  1  encoder accepts a byte this cycle.
- `tok`  output  3  run token, `{value, count[1:0]}`.
- `tok_valid`  output  1  `tok` is valid.
- `tok_ready`  input  1  downstream accepts the token.
- `byteIndx`  output  32  index of the byte currently being scanned.
- `bitIndx`  output  4  bit position being scanned, 7 down to 0.
- `done`  output  1  job complete.

## Operation
FSM states: IDLE, LOAD, SCAN, EMIT, FLUSH, DONE.

- **IDLE**
  - `work`=1 and `len`≠0: latch `len`, clear `byteIndx`, clear the run count, go to LOAD.
  - `work`=1 and `len`=0: go to DONE.
- **LOAD**
  - `in_ready`=1.
  - On `in_valid`&`in_ready`: capture the byte into a shift register, set `bitIndx`=7, go to SCAN.
- **SCAN**: examines bit b = byte[`bitIndx`], one bit per cycle.
  - Run count 0: start a run with value=b, count=1; consume b.
  - b==value and count<3: count+1; consume b.
  - Otherwise: load `tok`={value,count}, go to EMIT. Do not consume b; it is re-examined after the emit.
  - When bit 0 is consumed:
    - `byteIndx`==len−1: go to FLUSH.
    - Otherwise: `byteIndx`+1, go to LOAD.
  - Runs continue across byte boundaries; the run state is not cleared in LOAD.
- **EMIT**
  - `tok_valid`=1; `tok` is held stable until `tok_ready`.
  - On accept: clear the run count, return to SCAN.
- **FLUSH**
  - If the final run count is 0, go straight to DONE. This cannot happen for `len`>0 but must be handled.
  - Otherwise present {value,count} as in EMIT; on accept go to DONE.
- **DONE**
  - `done`=1.
  - Stay in DONE while `work`=1; go to IDLE when `work`=0.

Rules:
- A count of 0 is never emitted; legal tokens are 001–011 and 101–111.
- `len` and `byteIndx` are 32-bit unsigned; len−1 compares without wrap because `len`=0 is caught in IDLE.
- `work` outside IDLE/DONE is ignored.
- `in_valid` outside LOAD is ignored and no byte is consumed.

## Timing
- Reset (`rst_n`=0 at a clock edge) returns the FSM to IDLE and forces:
  - `in_ready`=0, `tok_valid`=0, `tok`=0, `done`=0, `byteIndx`=0, `bitIndx`=0.
- Reset mid-job aborts the job and discards the partial run. `tok_valid` is 0 from the cycle after the reset edge.
- All outputs are registered.
- `work` to `in_ready`: 1 cycle.
- Byte accept to first SCAN cycle: 1 cycle.
- Each bit costs 1 SCAN cycle.
- Each token costs at least 1 EMIT cycle, plus 1 cycle for the re-examined bit.
- Token handshake: a transfer occurs on a cycle with `tok_valid`&`tok_ready`. `tok_valid` never drops without a transfer except on reset. `tok_ready` may be held high permanently.
- Simultaneous `in_valid` and reset: reset wins and the byte is not consumed.
- `done` rises the cycle after the final token transfer.

## Configuration
- Macro `RLE_COMPRESS_TOKCNT_EN`.
  - Defined: adds output `tok_count` [31:0]. It resets to 0, clears on job start, and increments on every token transfer; it is valid and stable while `done`=1.
  - Undefined: the port and the counter are absent; all other behaviour is identical.

## Test plan
- `len`=1, byte 0x0F, `tok_ready`=1 → tokens 011, 001, 111, 101; then `done`=1 (`tok_count`=4 when the macro is defined).
- `len`=1, byte 0x00 → tokens 011, 011, 010; then `done`.
- `len`=2, bytes 0xFF, 0x80 (run crosses the byte boundary) → tokens 111, 111, 111, 011, 011, 001.
- `len`=1, byte 0x55, with `tok_ready` low for 5 cycles at the second token → token 101 stays stable with `tok_valid`=1 throughout; the full sequence is 001,101 repeated 4 times.
- `len`=0 → `done`=1 two cycles after `work`; no `tok_valid`; `in_ready` never asserts.
- `rst_n`=0 during SCAN of byte 0 of a 4-byte job → next cycle all outputs are 0 and the FSM is in IDLE. A new job with `len`=1, byte 0x0F then produces exactly 011, 001, 111, 101.
